id_rn_skid_stage: RTL and testbench
===================================

// Module: id_rn_skid_stage
// PURPOSE
//  Parametrised ID->RN pipeline stage for the superscalar front end. Carries a LANES-wide decode
//  group (per-lane valid + payload) with a valid/ready handshake. A 2-entry skid (main + skid reg)
//  gives full throughput while In_Ready is a pure register output. Adds sync flush, bubble-group
//  drop and a saturating back-pressure counter.
// PARAMETERS
//  LANES   2    decode lanes per group (>=1)
//  W       64   payload bits per lane
//  CNT_W   16   width of Stall_Cnt
// PORTS
//  Clk           in   1        clock, rising edge
//  Rst_n         in   1        async reset, active low
//  Flush         in   1        sync flush (branch mispredict / exception)
//  In_Valid      in   1        ID offers a group
//  In_Lane_Vld   in   LANES    per-lane valid of offered group
//  In_Data       in   LANES*W  lane payloads, lane 0 in LSBs
//  In_Ready      out  1        stage can take a group this cycle
//  Out_Valid     out  1        group presented to RN
//  Out_Lane_Vld  out  LANES    per-lane valid of presented group
//  Out_Data      out  LANES*W  presented payloads
//  Out_Ready     in   1        RN consumes presented group
//  Stall_Cnt     out  CNT_W    cycles with Out_Valid & !Out_Ready, saturating
// BEHAVIOUR
//  Reset (Rst_n=0, async): state EMPTY; In_Ready=1; Out_Valid=0; Out_Lane_Vld=0; Out_Data=0;
//   skid regs=0; Stall_Cnt=0. Release synchronous to Clk.
//  Events: acc = In_Valid & In_Ready; pop = Out_Valid & Out_Ready.
//   acc with In_Lane_Vld==0 is a bubble: consumed, discarded, no state change.
//   enq = acc & |In_Lane_Vld.
//  States: EMPTY (no group), ONE (main valid), TWO (main + skid valid).
//   EMPTY: enq -> ONE, main<=In.
//   ONE:   enq&pop -> ONE, main<=In;  enq&!pop -> TWO, skid<=In;  pop&!enq -> EMPTY.
//   TWO:   pop -> ONE, main<=skid (In_Ready=0 so no enq);  else hold.
//  Outputs (all registered): Out_Valid = (state!=EMPTY); Out_Lane_Vld/Out_Data = main regs;
//   In_Ready = (state!=TWO). No comb path In->Out or Out_Ready->In_Ready.
//  Latency: enq into EMPTY -> Out_Valid=1 next cycle. Throughput 1 group/cycle while Out_Ready=1.
//  Order: strict FIFO; a skid group never overtakes main.
//  Out_Valid/Out_Lane_Vld/Out_Data stay stable while Out_Valid & !Out_Ready.
//  Flush (sync, highest priority): next state EMPTY; main and skid lane-valid and data <= 0;
//   concurrent input group dropped even if acc; concurrent pop is still a valid RN handshake.
//   In_Ready=1 the cycle after flush.
//  Stall_Cnt: +1 each cycle Out_Valid & !Out_Ready (flush cycle included); holds at 2^CNT_W-1;
//   cleared only by reset.
//  Mid-operation reset: async clear of all state regardless of handshake in flight.
// TESTING
//  1 Reset: Rst_n=0 mid-traffic -> immediately Out_Valid=0, In_Ready=1, Stall_Cnt=0.
//  2 Streaming: Out_Ready=1, groups A,B,C on successive cycles -> Out A,B,C on cycles 1,2,3;
//    In_Ready stays 1.
//  3 Backpressure: enq A,B with Out_Ready=0 -> state TWO, In_Ready=0, Out=A held; Out_Ready=1
//    -> A then B, In_Ready=1 one cycle after A pops; Stall_Cnt equals stalled cycles.
//  4 Bubble: In_Valid=1, In_Lane_Vld=0 in EMPTY -> acc, Out_Valid stays 0; mask 2'b10 ->
//    Out_Lane_Vld=2'b10.
//  5 Flush: state TWO + Flush=1 + new group offered -> next cycle Out_Valid=0, Out_Data=0,
//    In_Ready=1; offered group never appears.
//  6 Saturation: CNT_W=4, hold Out_Ready=0 for 20 cycles -> Stall_Cnt stops at 15.

Source files
------------

// File: rtl/id_rn_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_rn_skid_stage
//  Description : ID->RN pipeline stage with a two-entry skid buffer.
//                in_ready is a pure register output. The stage drops
//                bubble groups, supports a synchronous flush and keeps a
//                saturating back-pressure counter.
//  Revision    : 1.0  initial release
// ============================================================================
module id_rn_skid_stage #(
  parameter int LANES = 2,
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [LANES-1:0]     in_lane_vld,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [LANES-1:0]     out_lane_vld,
  output logic [LANES*W-1:0]   out_data,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_e               state_q,     state_d;
  logic [LANES-1:0]     main_vld_q,  main_vld_d;
  logic [LANES*W-1:0]   main_data_q, main_data_d;
  logic [LANES-1:0]     skid_vld_q,  skid_vld_d;
  logic [LANES*W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic w_acc;
  logic w_enq;
  logic w_pop;
  logic w_stall;

  // Outputs come straight from registers: no combinational path from the
  // input side or from out_ready.
  assign in_ready     = (state_q != ST_TWO);
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_lane_vld = main_vld_q;
  assign out_data     = main_data_q;
  assign stall_cnt    = stall_cnt_q;

  // Next-state, datapath steering and stall counting.
  always_comb begin
    state_d     = state_q;
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;

    w_acc   = in_valid & in_ready;
    // A group with no valid lane is accepted but carries nothing.
    w_enq   = w_acc & (|in_lane_vld);
    w_pop   = out_valid & out_ready;
    w_stall = out_valid & ~out_ready;

    // The flush cycle itself still counts as a stall if RN is not ready.
    if (w_stall && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + c_cnt_one;
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      main_vld_d  = '0;
      main_data_d = '0;
      skid_vld_d  = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (w_enq) begin
            state_d     = ST_ONE;
            main_vld_d  = in_lane_vld;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (w_enq && w_pop) begin
            main_vld_d  = in_lane_vld;
            main_data_d = in_data;
          end else if (w_enq) begin
            state_d     = ST_TWO;
            skid_vld_d  = in_lane_vld;
            skid_data_d = in_data;
          end else if (w_pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid->main move can happen.
          if (w_pop) begin
            state_d     = ST_ONE;
            main_vld_d  = skid_vld_q;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_vld_q  <= '0;
      main_data_q <= '0;
      skid_vld_q  <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_vld_q  <= main_vld_d;
      main_data_q <= main_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_rn_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_rn_skid_stage
//  Description : Self-checking bench for id_rn_skid_stage. A queue model
//                runs alongside two DUT instances (16-bit and 4-bit stall
//                counters) sharing one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_rn_skid_stage;

  localparam int LANES = 2;
  localparam int W     = 16;
  localparam int DW    = LANES * W;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [LANES-1:0]  in_lane_vld;
  logic [DW-1:0]     in_data;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [LANES-1:0]  out_lane_vld;
  logic [DW-1:0]     out_data;
  logic [15:0]       stall_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [LANES-1:0]  s_out_lane_vld;
  logic [DW-1:0]     s_out_data;
  logic [3:0]        s_stall_cnt;

  int cmp_cnt = 0;
  int err_cnt = 0;

  id_rn_skid_stage #(.LANES(LANES), .W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_lane_vld(in_lane_vld), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_lane_vld(out_lane_vld), .out_data(out_data),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );

  id_rn_skid_stage #(.LANES(LANES), .W(W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_lane_vld(in_lane_vld), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_lane_vld(s_out_lane_vld), .out_data(s_out_data),
    .out_ready(out_ready), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of at most two groups --------
  logic [LANES-1:0] mq_vld[$];
  logic [DW-1:0]    mq_data[$];
  int               m_cnt16;
  int               m_cnt4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_vld.delete();
      mq_data.delete();
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      int  sz;
      bit  acc, pop, stall;
      sz    = mq_vld.size();
      acc   = in_valid && (sz < 2);
      pop   = (sz > 0) && out_ready;
      stall = (sz > 0) && !out_ready;
      if (stall) begin
        m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
        m_cnt4  = (m_cnt4  < 15)    ? m_cnt4  + 1 : 15;
      end
      if (flush) begin
        mq_vld.delete();
        mq_data.delete();
      end else begin
        if (pop) begin
          void'(mq_vld.pop_front());
          void'(mq_data.pop_front());
        end
        if (acc && (in_lane_vld != '0)) begin
          mq_vld.push_back(in_lane_vld);
          mq_data.push_back(in_data);
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model --------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
      chk("rst_stall",     {48'd0, stall_cnt}, 64'd0);
    end else begin
      chk("out_valid",   {63'd0, out_valid},   {63'd0, mq_vld.size() > 0});
      chk("in_ready",    {63'd0, in_ready},    {63'd0, mq_vld.size() < 2});
      chk("s_out_valid", {63'd0, s_out_valid}, {63'd0, mq_vld.size() > 0});
      chk("stall16",     {48'd0, stall_cnt},   64'(m_cnt16));
      chk("stall4",      {60'd0, s_stall_cnt}, 64'(m_cnt4));
      if (mq_vld.size() > 0) begin
        chk("out_lane_vld", {62'd0, out_lane_vld}, {62'd0, mq_vld[0]});
        chk("out_data",     {32'd0, out_data},     {32'd0, mq_data[0]});
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [DW-1:0] d);
    in_valid    = v;
    in_lane_vld = lv;
    in_data     = d;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  localparam logic [DW-1:0] GA = 32'hA1A1_A0A0;
  localparam logic [DW-1:0] GB = 32'hB1B1_B0B0;
  localparam logic [DW-1:0] GC = 32'hC1C1_C0C0;
  localparam logic [DW-1:0] GD = 32'hD1D1_D0D0;
  localparam logic [DW-1:0] GE = 32'hE1E1_E0E0;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, '0);
    #1;
    chk("init_out_valid", {63'd0, out_valid},    64'd0);
    chk("init_in_ready",  {63'd0, in_ready},     64'd1);
    chk("init_lane_vld",  {62'd0, out_lane_vld}, 64'd0);
    chk("init_data",      {32'd0, out_data},     64'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // Streaming at full rate
    drive(1'b1, 2'b11, GA); step();
    chk("stream_A", {32'd0, out_data}, {32'd0, GA});
    chk("stream_rdy_A", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 2'b11, GB); step();
    chk("stream_B", {32'd0, out_data}, {32'd0, GB});
    drive(1'b1, 2'b01, GC); step();
    chk("stream_C", {32'd0, out_data}, {32'd0, GC});
    chk("stream_C_lv", {62'd0, out_lane_vld}, 64'd1);
    drive(1'b0, 2'b00, '0); step();
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while two groups are held
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GA); step();
    drive(1'b1, 2'b11, GB); step();
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_in_ready",  {63'd0, in_ready},  64'd1);
    chk("async_stall",     {48'd0, stall_cnt}, 64'd0);
    drive(1'b0, 2'b00, '0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Back-pressure into the skid register
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GA); step();
    drive(1'b1, 2'b11, GB); step();
    drive(1'b0, 2'b00, '0);
    step(); step();
    chk("bp_in_ready", {63'd0, in_ready},  64'd0);
    chk("bp_hold_A",   {32'd0, out_data},  {32'd0, GA});
    chk("bp_stall",    {48'd0, stall_cnt}, 64'd3);
    out_ready = 1'b1;
    step();
    chk("bp_then_B",   {32'd0, out_data}, {32'd0, GB});
    chk("bp_rdy_back", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_empty",      {63'd0, out_valid}, 64'd0);
    chk("bp_stall_hold", {48'd0, stall_cnt}, 64'd3);

    // Bubble groups are swallowed
    drive(1'b1, 2'b00, GE); step();
    chk("bubble_no_valid", {63'd0, out_valid}, 64'd0);
    chk("bubble_ready",    {63'd0, in_ready},  64'd1);
    drive(1'b1, 2'b10, GD); step();
    chk("mask_lv",   {62'd0, out_lane_vld}, 64'd2);
    chk("mask_data", {32'd0, out_data},     {32'd0, GD});
    drive(1'b0, 2'b00, '0); step();

    // Flush with two groups held and a new group offered
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GA); step();
    drive(1'b1, 2'b11, GB); step();
    flush = 1'b1;
    drive(1'b1, 2'b11, GC); step();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0);
    chk("flush_valid", {63'd0, out_valid},    64'd0);
    chk("flush_data",  {32'd0, out_data},     64'd0);
    chk("flush_lv",    {62'd0, out_lane_vld}, 64'd0);
    chk("flush_ready", {63'd0, in_ready},     64'd1);
    repeat (3) step();
    chk("flush_no_C", {63'd0, out_valid}, 64'd0);

    // Flush in ONE with a group that is actually accepted
    drive(1'b1, 2'b11, GD); step();
    flush = 1'b1;
    drive(1'b1, 2'b11, GE); step();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0);
    chk("flush1_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("flush1_no_E", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    step();

    // Counter saturation on the 4-bit instance
    pulse_reset();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, GA); step();
    drive(1'b0, 2'b00, '0);
    repeat (20) step();
    chk("sat_cnt4",  {60'd0, s_stall_cnt}, 64'd15);
    chk("sat_cnt16", {48'd0, stall_cnt},   64'd20);
    out_ready = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
